// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, FSM states,
// write-back and access-size selectors, and the decoded-instruction record.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_LINK = 2'd2
   } wb_sel_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   typedef enum logic [3:0] {
      CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BEQ, CLS_BNE,
      CLS_J, CLS_JAL, CLS_JR, CLS_ILL
   } cls_e;

   typedef struct packed {
      cls_e       cls;
      logic [4:0] wb_dst;
      wb_sel_e    wb_sel;
      size_e      dm_size;
      logic       wb_write;
   } dec_t;

   // Control-flow classes resolve their target in EXEC.
   function automatic logic is_flow(cls_e c);
      return c inside {CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_JR};
   endfunction

   function automatic logic is_mem(cls_e c);
      return c inside {CLS_LOAD, CLS_STORE};
   endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction decode: class, destination register,
// write-back source and data-memory access size.
module mips_mc_decode
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [4:0] rt,
   input  logic [4:0] rd,
   input  logic [5:0] func,
   output dec_t       dec
);

   // NOTE: every field gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      dec = '{cls: CLS_ILL, wb_dst: rt, wb_sel: WB_ALU, dm_size: SZ_BYTE, wb_write: 1'b0};
      case (opcode)
         OP_RTYPE: begin
            dec.cls    = (func == FN_JR) ? CLS_JR : CLS_ALU;
            dec.wb_dst = rd;
         end
         OP_J:   dec.cls = CLS_J;
         OP_JAL: begin
            dec.cls    = CLS_JAL;
            dec.wb_dst = 5'd31;
            dec.wb_sel = WB_LINK;
         end
         OP_BEQ:                     dec.cls = CLS_BEQ;
         OP_BNE:                     dec.cls = CLS_BNE;
         OP_ADDIU, OP_SLTI, OP_LUI:  dec.cls = CLS_ALU;
         OP_LB, OP_LBU, OP_LW: begin
            dec.cls     = CLS_LOAD;
            dec.wb_sel  = WB_MEM;
            dec.dm_size = (opcode == OP_LW) ? SZ_WORD : SZ_BYTE;
         end
         OP_SB, OP_SW: begin
            dec.cls     = CLS_STORE;
            dec.dm_size = (opcode == OP_SW) ? SZ_WORD : SZ_BYTE;
         end
         default: ;
      endcase
      dec.wb_write = dec.cls inside {CLS_ALU, CLS_LOAD, CLS_JAL};
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control FSM and PC owner: sequences FETCH/DECODE/EXEC/MEM/WB
// per instruction class, stalls on memory busy and commits the PC at retire.
module mips_mc_ctrl
   import mips_pkg::*;
#(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  PC_INIT      = '0,
   parameter bit               EARLY_RETIRE = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     instr,
   input  logic            im_busy,
   input  logic            dm_busy,
   input  logic [XLEN-1:0] rs_data,
   input  logic [XLEN-1:0] rt_data,
   output logic [XLEN-1:0] pc,
   output logic            ir_load,
   output logic            ab_load,
   output logic            alu_load,
   output logic            dm_en,
   output logic            dm_rw,
   output logic [1:0]      dm_size,
   output logic            wb_en,
   output logic [1:0]      wb_sel,
   output logic [4:0]      wb_dst,
   output logic [XLEN-1:0] link_addr,
   output logic            illegal,
   output logic            retire,
   output logic [2:0]      state
);

   state_e          state_q, next_st;
   dec_t            dec_in, dec_q;
   logic [25:0]     idx_q;
   logic            retire_now, wb_wr;
   logic [XLEN-1:0] pc_plus4, br_target, pc_next;

   mips_mc_decode u_dec (
      .opcode (instr[31:26]),
      .rt     (instr[20:16]),
      .rd     (instr[15:11]),
      .func   (instr[5:0]),
      .dec    (dec_in)
   );

   always_comb begin
      next_st = state_q;
      unique case (state_q)
         FETCH:  if (!im_busy) next_st = DECODE;
         DECODE: next_st = EXEC;
         EXEC: begin
            if (is_flow(dec_q.cls))     next_st = EARLY_RETIRE ? FETCH : MEM;
            else if (is_mem(dec_q.cls)) next_st = MEM;
            else                        next_st = EARLY_RETIRE ? WB : MEM;
         end
         MEM: if (!(is_mem(dec_q.cls) && dm_busy))
            next_st = (EARLY_RETIRE && dec_q.cls == CLS_STORE) ? FETCH : WB;
         WB:      next_st = FETCH;
         default: next_st = FETCH;
      endcase
   end

   assign retire_now = (state_q != FETCH) && (next_st == FETCH);
   assign wb_wr      = (next_st == WB && dec_q.wb_write) ||
                       (EARLY_RETIRE && next_st == EXEC && dec_q.cls == CLS_JAL);

   assign pc_plus4  = pc + XLEN'(4);
   assign br_target = pc_plus4 + {{(XLEN-18){idx_q[15]}}, idx_q[15:0], 2'b00};

   always_comb begin
      unique case (dec_q.cls)
         CLS_BEQ:          pc_next = (rs_data == rt_data) ? br_target : pc_plus4;
         CLS_BNE:          pc_next = (rs_data != rt_data) ? br_target : pc_plus4;
         CLS_J, CLS_JAL:   pc_next = {pc_plus4[XLEN-1:28], idx_q, 2'b00};
         CLS_JR:           pc_next = rs_data;
         default:          pc_next = pc_plus4;
      endcase
   end

   // NOTE: these qualify on same-cycle busy inputs, so they are decoded
   // combinationally and masked by reset so an aborted instruction never retires.
   assign ir_load = (state_q == FETCH) && !im_busy && !reset;
   assign retire  = retire_now && !reset;
   assign illegal = retire && (dec_q.cls == CLS_ILL);
   assign state   = state_q;

   // NOTE: all state here uses non-blocking assignment; outputs are set on the
   // transition into the state in which they must be seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         pc        <= PC_INIT;
         dec_q     <= '0;
         idx_q     <= '0;
         link_addr <= '0;
         ab_load   <= 1'b0;
         alu_load  <= 1'b0;
         dm_en     <= 1'b0;
         dm_rw     <= 1'b1;
         dm_size   <= '0;
         wb_en     <= 1'b0;
         wb_sel    <= '0;
         wb_dst    <= '0;
      end else begin
         state_q <= next_st;
         if (state_q == FETCH && !im_busy) begin
            dec_q     <= dec_in;
            idx_q     <= instr[25:0];
            link_addr <= pc + XLEN'(8);
         end
         if (retire_now) pc <= pc_next;
         ab_load  <= (next_st == DECODE);
         alu_load <= (next_st == EXEC);
         dm_en    <= (next_st == MEM) && is_mem(dec_q.cls);
         dm_rw    <= !((next_st == MEM) && dec_q.cls == CLS_STORE);
         if (next_st == DECODE)                dm_size <= dec_in.dm_size;
         else if (next_st inside {EXEC, MEM})  dm_size <= dec_q.dm_size;
         else                                  dm_size <= '0;
         wb_en  <= wb_wr;
         wb_sel <= wb_wr ? dec_q.wb_sel : WB_ALU;
         wb_dst <= wb_wr ? dec_q.wb_dst : 5'd0;
      end
   end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench: the driver pushes hand-computed retire records, a
// negedge monitor pops and compares them whenever the active DUT retires.
module tb_mips_mc_ctrl;
   import mips_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] instr, rs, rt;
      int          im_b, dm_b, cycles;
      logic [31:0] pc0, pc1;
      logic        wb_en;
      logic [4:0]  dst;
      logic [1:0]  sel;
      logic        ill;
      int          n_dm, n_wr;
      logic [1:0]  dsz;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_e, reset_l, use_l;
   logic [31:0] instr, rs_data, rt_data;
   logic        im_busy, dm_busy;

   logic [31:0] pc_e, pc_l, link_e, link_l;
   logic        ir_e, ir_l, ab_e, ab_l, alu_e, alu_l, dme_e, dme_l, rw_e, rw_l;
   logic        wbe_e, wbe_l, ill_e, ill_l, ret_e, ret_l;
   logic [1:0]  sz_e, sz_l, sel_e, sel_l;
   logic [4:0]  dst_e, dst_l;
   logic [2:0]  st_e, st_l;

   int   n_chk = 0, n_fail = 0;
   vec_t sb[$];

   always #5 clk = ~clk;

   mips_mc_ctrl #(.XLEN(32), .PC_INIT(32'h0), .EARLY_RETIRE(1'b1)) dut_e (
      .clk(clk), .reset(reset_e), .instr(instr), .im_busy(im_busy), .dm_busy(dm_busy),
      .rs_data(rs_data), .rt_data(rt_data), .pc(pc_e), .ir_load(ir_e), .ab_load(ab_e),
      .alu_load(alu_e), .dm_en(dme_e), .dm_rw(rw_e), .dm_size(sz_e), .wb_en(wbe_e),
      .wb_sel(sel_e), .wb_dst(dst_e), .link_addr(link_e), .illegal(ill_e),
      .retire(ret_e), .state(st_e));

   mips_mc_ctrl #(.XLEN(32), .PC_INIT(32'h100), .EARLY_RETIRE(1'b0)) dut_l (
      .clk(clk), .reset(reset_l), .instr(instr), .im_busy(im_busy), .dm_busy(dm_busy),
      .rs_data(rs_data), .rt_data(rt_data), .pc(pc_l), .ir_load(ir_l), .ab_load(ab_l),
      .alu_load(alu_l), .dm_en(dme_l), .dm_rw(rw_l), .dm_size(sz_l), .wb_en(wbe_l),
      .wb_sel(sel_l), .wb_dst(dst_l), .link_addr(link_l), .illegal(ill_l),
      .retire(ret_l), .state(st_l));

   // Observe whichever DUT is currently out of reset.
   logic [31:0] m_pc, m_link;
   logic        m_reset, m_ir, m_ab, m_alu, m_dm_en, m_dm_rw, m_wb_en, m_ill, m_retire;
   logic [1:0]  m_dsz, m_sel;
   logic [4:0]  m_dst;
   logic [2:0]  m_state;
   assign m_reset  = use_l ? reset_l : reset_e;
   assign m_pc     = use_l ? pc_l    : pc_e;
   assign m_link   = use_l ? link_l  : link_e;
   assign m_ir     = use_l ? ir_l    : ir_e;
   assign m_ab     = use_l ? ab_l    : ab_e;
   assign m_alu    = use_l ? alu_l   : alu_e;
   assign m_dm_en  = use_l ? dme_l   : dme_e;
   assign m_dm_rw  = use_l ? rw_l    : rw_e;
   assign m_dsz    = use_l ? sz_l    : sz_e;
   assign m_wb_en  = use_l ? wbe_l   : wbe_e;
   assign m_sel    = use_l ? sel_l   : sel_e;
   assign m_dst    = use_l ? dst_l   : dst_e;
   assign m_ill    = use_l ? ill_l   : ill_e;
   assign m_retire = use_l ? ret_l   : ret_e;
   assign m_state  = use_l ? st_l    : st_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t v(string name, logic [31:0] instr_i, rs, rt, int im_b, dm_b,
                              cycles, logic [31:0] pc0, pc1, logic wb_en, logic [4:0] dst,
                              logic [1:0] sel, logic ill, int n_dm, n_wr, logic [1:0] dsz);
      vec_t x;
      x.name = name; x.instr = instr_i; x.rs = rs; x.rt = rt; x.im_b = im_b; x.dm_b = dm_b;
      x.cycles = cycles; x.pc0 = pc0; x.pc1 = pc1; x.wb_en = wb_en; x.dst = dst;
      x.sel = sel; x.ill = ill; x.n_dm = n_dm; x.n_wr = n_wr; x.dsz = dsz;
      return x;
   endfunction

   // Monitor: per-instruction counters, compared against the record at retire.
   int          cnt, c_dm, c_wr, c_ir, c_ab, c_alu;
   logic        pend = 1'b0;
   logic [31:0] exp_pc;
   string       pend_name;
   always @(negedge clk) begin
      if (m_reset) begin
         cnt = 0; c_dm = 0; c_wr = 0; c_ir = 0; c_ab = 0; c_alu = 0; pend = 1'b0;
      end else begin
         if (pend) begin
            check({pend_name, ".pc_next"}, m_pc, exp_pc);
            pend = 1'b0;
         end
         cnt++;
         if (m_dm_en)  c_dm++;
         if (!m_dm_rw) c_wr++;
         if (m_ir)     c_ir++;
         if (m_ab)     c_ab++;
         if (m_alu)    c_alu++;
         if (m_dm_en && sb.size() > 0) check({sb[0].name, ".dm_size"}, m_dsz, sb[0].dsz);
         if (m_retire) begin
            if (sb.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_retire: got retire=1 at pc 0x%08h expected none", m_pc);
            end else begin
               automatic vec_t e = sb.pop_front();
               check({e.name, ".cycles"},  cnt,     e.cycles);
               check({e.name, ".wb_en"},   m_wb_en, e.wb_en);
               if (e.wb_en) begin
                  check({e.name, ".wb_dst"}, m_dst, e.dst);
                  check({e.name, ".wb_sel"}, m_sel, e.sel);
               end
               check({e.name, ".illegal"}, m_ill,   e.ill);
               check({e.name, ".link"},    m_link,  e.pc0 + 32'd8);
               check({e.name, ".dm_en_n"}, c_dm,    e.n_dm);
               check({e.name, ".dm_wr_n"}, c_wr,    e.n_wr);
               check({e.name, ".loads_n"}, {c_ir[7:0], c_ab[7:0], c_alu[7:0]}, 32'h010101);
               exp_pc = e.pc1; pend_name = e.name; pend = 1'b1;
            end
            cnt = 0; c_dm = 0; c_wr = 0; c_ir = 0; c_ab = 0; c_alu = 0;
         end
      end
   end

   task automatic wait_retire(input string name);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!m_retire && k < 100);
      if (!m_retire) begin
         n_chk++; n_fail++;
         $display("FAIL %s.timeout: got no retire in 100 cycles expected retire", name);
      end
      @(posedge clk); #1;
   endtask

   // Called at the start of a FETCH cycle; returns at the start of the next one.
   task automatic run(input vec_t x);
      instr = x.instr; rs_data = x.rs; rt_data = x.rt;
      sb.push_back(x);
      if (x.im_b > 0) begin
         im_busy = 1'b1;
         repeat (x.im_b) @(posedge clk);
         #1 im_busy = 1'b0;
      end
      if (x.dm_b > 0) begin
         dm_busy = 1'b1;
         repeat (x.dm_b + 3) @(posedge clk);
         #1 dm_busy = 1'b0;
      end
      wait_retire(x.name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got time limit expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      reset_e = 1'b1; reset_l = 1'b1; use_l = 1'b0;
      instr = '0; rs_data = '0; rt_data = '0; im_busy = 1'b0; dm_busy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.state", m_state, FETCH);
      check("rst.pc", m_pc, 32'h0);
      check("rst.dm_rw", m_dm_rw, 1'b1);
      check("rst.link", m_link, 32'h0);
      check("rst.strobes", {m_ir, m_ab, m_alu, m_dm_en, m_wb_en, m_ill, m_retire, m_dsz, m_sel, m_dst},
            '0);
      @(posedge clk); #1 reset_e = 1'b0;

      //     name      instr         rs            rt          imb dmb cyc pc0          pc1          wb dst sel il ndm nwr sz
      run(v("addiu",   32'h24080005, 0,            0,            0, 0, 4, 32'h0,      32'h4,       1, 8,  0, 0, 0, 0, 0));
      run(v("j100",    32'h08000040, 0,            0,            0, 0, 3, 32'h4,      32'h100,     0, 0,  0, 0, 0, 0, 0));
      run(v("beq_t",   32'h10220003, 7,            7,            0, 0, 3, 32'h100,    32'h110,     0, 0,  0, 0, 0, 0, 0));
      run(v("bne_nt",  32'h14220003, 7,            7,            0, 0, 3, 32'h110,    32'h114,     0, 0,  0, 0, 0, 0, 0));
      run(v("bne_neg", 32'h1422FFFE, 7,            9,            0, 0, 3, 32'h114,    32'h110,     0, 0,  0, 0, 0, 0, 0));
      run(v("lw_busy", 32'h8C290000, 0,            0,            0, 3, 8, 32'h110,    32'h114,     1, 9,  1, 0, 4, 0, 2));
      run(v("sw",      32'hAC290000, 0,            0,            0, 0, 4, 32'h114,    32'h118,     0, 0,  0, 0, 1, 1, 2));
      run(v("lb",      32'h80290000, 0,            0,            0, 0, 5, 32'h118,    32'h11C,     1, 9,  1, 0, 1, 0, 0));
      run(v("j1000",   32'h08000400, 0,            0,            0, 0, 3, 32'h11C,    32'h1000,    0, 0,  0, 0, 0, 0, 0));
      run(v("jal",     32'h0C000040, 0,            0,            0, 0, 3, 32'h1000,   32'h100,     1, 31, 2, 0, 0, 0, 0));
      run(v("jr",      32'h00200008, 32'h2000,     0,            0, 0, 3, 32'h100,    32'h2000,    0, 0,  0, 0, 0, 0, 0));
      run(v("addu_ib", 32'h00225021, 0,            0,            2, 0, 6, 32'h2000,   32'h2004,    1, 10, 0, 0, 0, 0, 0));
      run(v("illegal", 32'hFC000000, 0,            0,            0, 0, 4, 32'h2004,   32'h2008,    0, 0,  0, 1, 0, 0, 0));

      // Abort a store in MEM with reset; the aborted store must leave no trace.
      instr = 32'hAC290000; dm_busy = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (m_state != MEM && k < 20);
      check("abort.reached_mem", m_state, MEM);
      @(posedge clk); #1 reset_e = 1'b1; dm_busy = 1'b0;
      @(negedge clk);
      check("abort.retire_in_reset", m_retire, 1'b0);
      @(posedge clk); #1 reset_e = 1'b0; im_busy = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("abort.state", m_state, FETCH);
         check("abort.pc", m_pc, 32'h0);
         check("abort.dm_rw", m_dm_rw, 1'b1);
         check("abort.retire", m_retire, 1'b0);
      end
      @(posedge clk); #1 reset_e = 1'b1; im_busy = 1'b0;
      @(posedge clk); #1 reset_e = 1'b0;

      run(v("jr_top",  32'h00200008, 32'hFFFFFFFC, 0,            0, 0, 3, 32'h0,      32'hFFFFFFFC,0, 0,  0, 0, 0, 0, 0));
      run(v("nop_wrap",32'h00000000, 0,            0,            0, 0, 4, 32'hFFFFFFFC,32'h0,      1, 0,  0, 0, 0, 0, 0));
      @(negedge clk);

      // Legacy-timing instance: every instruction takes five states.
      @(posedge clk); #1 reset_e = 1'b1; use_l = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("lrst.pc", m_pc, 32'h100);
      check("lrst.state", m_state, FETCH);
      @(posedge clk); #1 reset_l = 1'b0;

      run(v("l_beq",   32'h10220003, 7,            7,            0, 0, 5, 32'h100,    32'h110,     0, 0,  0, 0, 0, 0, 0));
      run(v("l_addiu", 32'h24080005, 0,            0,            0, 0, 5, 32'h110,    32'h114,     1, 8,  0, 0, 0, 0, 0));
      run(v("l_sw",    32'hAC290000, 0,            0,            0, 0, 5, 32'h114,    32'h118,     0, 0,  0, 0, 1, 1, 2));
      run(v("l_jal",   32'h0C000040, 0,            0,            0, 0, 5, 32'h118,    32'h100,     1, 31, 2, 0, 0, 0, 0));
      run(v("l_lw",    32'h8C290000, 0,            0,            0, 3, 8, 32'h100,    32'h104,     1, 9,  1, 0, 4, 0, 2));
      im_busy = 1'b1;
      repeat (2) @(negedge clk);
      check("sb.drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Parametrised multi-cycle control unit and PC owner for the single-issue MIPS core.
- Replaces the fixed 5-count sequencer with an explicit FETCH/DECODE/EXEC/MEM/WB state machine.
- Number of states per instruction depends on instruction class. The FSM stalls on instruction- and data-memory busy.
- Drives all register, ALU-latch, data-memory and write-back enables; regfile, ALU and memories remain separate blocks.

Parameters:
- XLEN, 32: datapath/PC width; must be >= 32.
- PC_INIT, 0: PC value after reset.
- EARLY_RETIRE, 1: 1 = variable-length instructions; 0 = every instruction takes exactly 5 states (legacy-timing mode).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- instr  in  32  instruction-memory read data.
- im_busy  in  1  instruction memory not ready.
- dm_busy  in  1  data memory not ready.
- rs_data  in  XLEN  regfile read port 0 (rs).
- rt_data  in  XLEN  regfile read port 1 (rt).
- pc  out  XLEN  current PC, drives instruction-memory address.
- ir_load  out  1  latch instr into instruction register.
- ab_load  out  1  latch A/B operand registers.
- alu_load  out  1  latch ALU result register.
- dm_en  out  1  data-memory access strobe.
- dm_rw  out  1  1 = read, 0 = write.
- dm_size  out  2  0 = byte, 1 = half, 2 = word.
- wb_en  out  1  regfile write enable.
- wb_sel  out  2  0 = ALU, 1 = memory, 2 = link.
- wb_dst  out  5  regfile write index.
- link_addr  out  XLEN  pc+8.
- illegal  out  1  one-cycle pulse at retire of an undecoded opcode.
- retire  out  1  one-cycle pulse when an instruction completes.
- state  out  3  current FSM state (debug).

Behaviour:
Reset:
- Synchronous reset, clock clk; reset is active-high.
- On reset: state = FETCH, pc = PC_INIT, dm_rw = 1, all other outputs 0.
- Reset asserted in any state aborts the instruction; no write-back, no PC change, no retire.

Decode (from the latched IR):
- R-type 000000; JR = R-type with func 001000, any rs.
- J 000010, JAL 000011, BEQ 000100, BNE 000101.
- ADDIU 001001, SLTI 001010, LUI 001111.
- LB 100000, LBU 100100, LW 100011.
- SB 101000, SW 101011.
- Any other opcode is illegal: executes as a NOP.

States:
- FETCH:
  - Stay while im_busy.
  - When !im_busy: ir_load = 1 for one cycle, go to DECODE.
- DECODE:
  - ab_load = 1, go to EXEC.
- EXEC:
  - alu_load = 1.
  - Branch/J/JAL/JR: compute target. With EARLY_RETIRE = 1, commit PC and retire here, then go to FETCH. With EARLY_RETIRE = 0, go to MEM, then WB (idle states), and commit there.
  - Load/store: go to MEM.
  - Everything else: go to WB (EARLY_RETIRE = 1), or MEM then WB (EARLY_RETIRE = 0).
- MEM:
  - dm_en = 1 for loads/stores.
  - dm_rw = 0 only for SB/SW, and only while in MEM.
  - Stay while dm_busy.
  - On !dm_busy: a store retires and goes to FETCH (EARLY_RETIRE = 1), or goes to WB with no write (EARLY_RETIRE = 0); a load goes to WB.
- WB:
  - wb_en = 1 except for store, branch, J, JR and illegal.
  - Commit PC, retire = 1, go to FETCH.

PC commit (at the retire cycle only):
- BEQ taken when rs_data == rt_data; BNE taken when they differ. Taken target = pc+4+(sext(imm)<<2); not taken = pc+4.
- J/JAL target = {pc_plus4[XLEN-1:28], instr[25:0], 2'b00}.
- JR target = rs_data.
- Default = pc+4.
- All PC arithmetic is modulo 2^XLEN; wrap-around is silent.

Write-back:
- wb_dst: 31 for JAL; rt for I-type/loads; rd for R-type.
- wb_sel: link for JAL, memory for loads, ALU otherwise.

Cycle counts (no busy):
- EARLY_RETIRE = 1: branch/jump 3; ALU and store 4; load 5.
- EARLY_RETIRE = 0: always 5.

Other rules:
- Each busy cycle adds exactly one cycle.
- dm_size is held from DECODE through MEM.
- im_busy is ignored outside FETCH; dm_busy is ignored outside MEM.

Decomposition:
- Shared package mips_pkg:
  - opcode and func localparams.
  - state_e enum (FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4).
  - wb_sel_e and size encodings.
- One natural sub-module, mips_mc_decode: combinational instruction class / wb_dst / dm_size / illegal decode, instantiated by the FSM.

Test Plan:
- Reset, then ADDIU $t0, $zero, 5 with no busy -> retire at cycle 4, wb_en = 1, wb_dst = 8, wb_sel = 0, pc 0 -> 4.
- BEQ with rs_data = rt_data = 7, imm = 0x0003, pc = 0x100 -> retire at cycle 3, pc = 0x110. Repeat with EARLY_RETIRE = 0 -> retire at cycle 5, same pc.
- LW with dm_busy high for 3 cycles in MEM -> dm_en held 4 cycles, retire at cycle 8, wb_sel = 1.
- JAL instr[25:0] = 0x40, pc = 0x1000 -> pc = 0x100, wb_dst = 31, link_addr = 0x1008. JR with rs_data = 0x2000 -> pc = 0x2000, wb_en = 0.
- Reset asserted during MEM of SW -> no dm_rw = 0 cycle after reset, state = FETCH, pc = PC_INIT, retire never pulses.
- Opcode 111111 -> illegal pulse at retire, wb_en = 0, pc += 4. pc = 0xFFFFFFFC with NOP -> pc wraps to 0.
